// File: rtl/vga_plot_sink.sv
// ---------------------------------------------------------------------------
// vga_plot_sink
//
// Responder side of the pixel plot interface. Plotted pixels are stored in a
// 1-bit IMAGE_W x IMAGE_H frame buffer and scanned out continuously as
// 640x480@60 VGA, each stored pixel doubled to a 2x2 screen block. The buffer
// is swept to zero after reset and whenever a clear is requested.
//
// Ports
//   clock      system clock (50 MHz), the only clock
//   reset      synchronous, active-high reset
//   x, y       plot coordinate (column 0..IMAGE_W-1, row 0..IMAGE_H-1)
//   colour     pixel value to store
//   plot       write strobe, one pixel per clock while high
//   clear      single-cycle request to zero the whole buffer
//   busy       high while a clear sweep is in progress (plots are dropped)
//   VGA_CLK    25 MHz pixel clock
//   VGA_HS     horizontal sync, active low
//   VGA_VS     vertical sync, active low
//   VGA_BLANK  low during blanking
//   VGA_SYNC   tied low
//   VGA_R/G/B  FG_LEVEL for a stored 1, BG_LEVEL for a stored 0, 0 when blanked
// ---------------------------------------------------------------------------
module vga_plot_sink #(
    parameter int         IMAGE_W  = 320,
    parameter int         IMAGE_H  = 240,
    parameter logic [9:0] FG_LEVEL = 10'h3FF,
    parameter logic [9:0] BG_LEVEL = 10'h000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic       colour,
    input  logic       plot,
    input  logic       clear,
    output logic       busy,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    // -----------------------------------------------------------------------
    // Geometry
    // -----------------------------------------------------------------------
    localparam int DEPTH = IMAGE_W * IMAGE_H;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(IMAGE_W);
    localparam logic [8:0]    X_LIMIT    = 9'(IMAGE_W);
    localparam logic [7:0]    Y_LIMIT    = 8'(IMAGE_H);

    // Screen timing in pixel periods (horizontal) and lines (vertical).
    // *_SYNC_END is the first position after the sync pulse.
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    // -----------------------------------------------------------------------
    // Control FSM: CLEAR sweeps the buffer to zero, IDLE accepts plots
    // -----------------------------------------------------------------------
    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_addr;
    logic [AW-1:0]   clr_addr_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // NOTE: every output of a combinational block gets a default on entry, so
    // no path through the case statement leaves a value unassigned (no latch).
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            CLEAR: begin
                if (clear) begin
                    clr_addr_next = '0;
                end else if (clr_addr == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + 1'b1;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // -----------------------------------------------------------------------
    // Frame buffer write port: the sweep owns it while clearing, otherwise an
    // in-range plot writes on the same edge it is sampled. Range is checked
    // per axis so an oversized x can never spill into the next row.
    // -----------------------------------------------------------------------
    logic          plot_in_range;
    logic [AW-1:0] plot_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;

    assign plot_in_range = (x < X_LIMIT) && (y < Y_LIMIT);
    assign plot_addr     = AW'(y) * ROW_STRIDE + AW'(x);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_data = 1'b0;
        if (state == CLEAR) begin
            wr_en = 1'b1;
        end else if (plot && plot_in_range && !clear) begin
            wr_en   = 1'b1;
            wr_addr = plot_addr;
            wr_data = colour;
        end
    end

    // NOTE: the storage array has no reset branch; a reset term would stop it
    // mapping onto block RAM. Its contents are zeroed by the clear sweep.
    logic          frame_mem [0:DEPTH-1];
    logic [AW-1:0] rd_addr;
    logic          rd_data;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a read of the address being written returns old data.
    always_ff @(posedge clock) begin
        rd_data <= frame_mem[rd_addr];
    end

    // -----------------------------------------------------------------------
    // Scan counters. pe alternates every clock so the counters advance at the
    // 25 MHz pixel rate. VGA_CLK is registered so it can be held low in reset
    // and otherwise equals ~pe.
    // -----------------------------------------------------------------------
    logic       pe;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            pe      <= 1'b0;
            VGA_CLK <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            pe      <= ~pe;
            VGA_CLK <= pe;
            if (pe) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    logic visible;
    logic hs_now;
    logic vs_now;

    assign visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    assign hs_now  = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign vs_now  = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));

    // Read address follows the scan only while visible and is held in the
    // blanking intervals, so the RAM sees no address activity there.
    logic [AW-1:0] rd_addr_hold;

    always_comb begin
        rd_addr = rd_addr_hold;
        if (visible) begin
            rd_addr = AW'(v_cnt[9:1]) * ROW_STRIDE + AW'(h_cnt[9:1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_hold <= '0;
        end else begin
            rd_addr_hold <= rd_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Output pipeline. Stage 1 lines the sync/blank flags up with the RAM
    // read; stage 2 registers everything to the pins, so all outputs trail
    // the counters by exactly two clocks.
    // -----------------------------------------------------------------------
    logic       hs_s1;
    logic       vs_s1;
    logic       blank_s1;
    logic [9:0] level;

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
            blank_s1  <= 1'b0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            level     <= '0;
        end else begin
            hs_s1     <= hs_now;
            vs_s1     <= vs_now;
            blank_s1  <= visible;
            VGA_HS    <= hs_s1;
            VGA_VS    <= vs_s1;
            VGA_BLANK <= blank_s1;
            if (!blank_s1) begin
                level <= '0;
            end else if (rd_data) begin
                level <= FG_LEVEL;
            end else begin
                level <= BG_LEVEL;
            end
        end
    end

    assign VGA_R    = level;
    assign VGA_G    = level;
    assign VGA_B    = level;
    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_plot_sink.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_sink
//
// Directed sequence with randomized plots. The expected screen is derived
// from elapsed clocks since reset release: output at clock t shows pixel
// n = (t-2)/2 of the 800x525 raster, and a visible pixel shows the stored
// bit at buffer row v/2, column h/2 of the bench's own picture array.
// ---------------------------------------------------------------------------
module tb_vga_plot_sink;

    logic       clock;
    logic       reset;
    logic [8:0] x;
    logic [7:0] y;
    logic       colour;
    logic       plot;
    logic       clear;
    logic       busy;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK;
    logic       VGA_SYNC;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;

    vga_plot_sink dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .clear     (clear),
        .busy      (busy),
        .VGA_CLK   (VGA_CLK),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_BLANK (VGA_BLANK),
        .VGA_SYNC  (VGA_SYNC),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests;
    int fails;
    int t;          // clock edges since reset was released
    bit scan_on;    // compare the VGA outputs every clock
    bit rgb_on;     // picture model is valid for visible pixels
    int rgb_from;
    int hs_low;
    int blank_hi;
    bit fb [0:239][0:319];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_scan();
        int  n = 0;
        int  h = 0;
        int  v = 0;
        bit  e_hs;
        bit  e_vs;
        bit  e_blank;
        logic [9:0] e_rgb;
        if (t < 2) begin
            e_hs    = 1'b1;
            e_vs    = 1'b1;
            e_blank = 1'b0;
        end else begin
            n       = (t - 2) / 2;
            h       = n % 800;
            v       = (n / 800) % 525;
            e_hs    = !(h >= 656 && h < 752);
            e_vs    = !(v >= 490 && v < 492);
            e_blank = (h < 640) && (v < 480);
        end
        check("hs", VGA_HS, e_hs);
        check("vs", VGA_VS, e_vs);
        check("blank", VGA_BLANK, e_blank);
        check("vga_clk", VGA_CLK, (t % 2) == 0);
        check("vga_sync", VGA_SYNC, 1'b0);
        if (!e_blank) begin
            check("rgb_blanked", {2'b00, VGA_R, VGA_G, VGA_B}, 32'h0);
        end else if (rgb_on && t >= rgb_from) begin
            e_rgb = fb[v / 2][h / 2] ? 10'h3FF : 10'h000;
            check("r", VGA_R, e_rgb);
            check("g", VGA_G, e_rgb);
            check("b", VGA_B, e_rgb);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        t++;
        if (scan_on) check_scan();
    endtask

    task automatic check_reset_state();
        check("rst_hs", VGA_HS, 1'b1);
        check("rst_vs", VGA_VS, 1'b1);
        check("rst_blank", VGA_BLANK, 1'b0);
        check("rst_rgb", {2'b00, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("rst_vga_clk", VGA_CLK, 1'b0);
        check("rst_busy", busy, 1'b1);
    endtask

    task automatic clear_model();
        for (int r = 0; r < 240; r++)
            for (int c = 0; c < 320; c++)
                fb[r][c] = 1'b0;
    endtask

    // One-cycle plot; the model stores it only when the bench expects the
    // block to be idle and the coordinate is inside the picture.
    task automatic do_plot(input int px, input int py, input bit c, input bit idle);
        x      = 9'(px);
        y      = 8'(py);
        colour = c;
        plot   = 1'b1;
        tick();
        plot   = 1'b0;
        if (idle && px < 320 && py < 240) fb[py][px] = c;
    endtask

    initial begin
        bit done;
        int px;
        int py;
        bit pc;

        tests    = 0;
        fails    = 0;
        t        = 0;
        scan_on  = 1'b0;
        rgb_on   = 1'b0;
        rgb_from = 0;
        hs_low   = 0;
        blank_hi = 0;
        reset    = 1'b1;
        x        = '0;
        y        = '0;
        colour   = 1'b0;
        plot     = 1'b0;
        clear    = 1'b0;
        clear_model();

        // Reset state
        repeat (3) tick();
        check_reset_state();

        // Power-up sweep: busy for exactly 76800 clocks. Plots near its end
        // target row 24, already cleared, and must be dropped.
        reset   = 1'b0;
        t       = 0;
        scan_on = 1'b1;
        done    = 1'b0;
        while (!done && t < 80000) begin
            if (t >= 70000 && t < 70010) begin
                x      = 9'($urandom_range(0, 319));
                y      = 8'd24;
                colour = 1'b1;
                plot   = 1'b1;
            end else begin
                plot   = 1'b0;
            end
            tick();
            check("busy_sweep", busy, t < 76800);
            if (t >= 2000 && t < 3600) begin
                hs_low   += (VGA_HS === 1'b0) ? 1 : 0;
                blank_hi += (VGA_BLANK === 1'b1) ? 1 : 0;
            end
            if (t == 3599) begin
                check("hs_low_per_line", hs_low, 192);
                check("blank_high_per_line", blank_hi, 1280);
            end
            if (busy === 1'b0) done = 1'b1;
        end
        check("busy_length", t, 76800);

        // Buffer is now all zero; picture checks start once the read
        // pipeline has seen only post-sweep contents.
        rgb_on   = 1'b1;
        rgb_from = t + 3;

        // Directed plots, including coordinates that must not alias
        do_plot(10, 25, 1'b1, 1'b1);
        do_plot(319, 26, 1'b1, 1'b1);
        do_plot(320, 25, 1'b1, 1'b1);
        do_plot(0, 240, 1'b1, 1'b1);
        do_plot(511, 26, 1'b1, 1'b1);
        do_plot(5, 255, 1'b1, 1'b1);

        // Random plots into rows 25..26 (screen lines 50..53), some out of
        // range, some idle cycles with plot low
        for (int i = 0; i < 48; i++) begin
            px = int'($urandom_range(0, 399));
            py = int'($urandom_range(25, 26));
            if ($urandom_range(0, 7) == 0) py = int'($urandom_range(240, 255));
            pc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                x      = 9'(px);
                y      = 8'(py);
                colour = pc;
                plot   = 1'b0;
                tick();
            end else begin
                do_plot(px, py, pc, 1'b1);
            end
        end

        // Clear with a simultaneous plot, a plot while busy, and a second
        // clear mid-sweep. Row 27 is read on screen lines 54..55 long before
        // the sweep reaches it, so any leaked plot shows up there.
        while (t < 86000) tick();
        x      = 9'd150;
        y      = 8'd27;
        colour = 1'b1;
        plot   = 1'b1;
        clear  = 1'b1;
        tick();
        plot   = 1'b0;
        clear  = 1'b0;
        check("busy_after_clear", busy, 1'b1);
        repeat (99) tick();
        do_plot(200, 27, 1'b1, 1'b0);
        repeat (200) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        while (t < 89602) begin
            tick();
            check("busy_clearing", busy, 1'b1);
        end

        // Reset in the middle of a horizontal sync pulse
        while (((t - 2) / 2) % 800 != 700 && t < 95000) tick();
        check("hs_before_reset", VGA_HS, 1'b0);
        scan_on = 1'b0;
        reset   = 1'b1;
        tick();
        check_reset_state();
        tick();
        check_reset_state();

        // Scan restarts from h=0, v=0; the buffer is being swept behind the
        // scan so every visible pixel reads as background.
        reset    = 1'b0;
        t        = 0;
        clear_model();
        rgb_from = 0;
        scan_on  = 1'b1;
        done     = 1'b0;
        while (!done && t < 3000) begin
            tick();
            if (VGA_HS === 1'b0) done = 1'b1;
        end
        check("first_hs_fall", t, 2 * 656 + 2);
        check("busy_after_reset", busy, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
